// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface memory_stage_if #(
    parameter int REG_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  O_MemReq;
    logic                  O_MemWe;
    logic [ADDR_WIDTH-1:0] O_MemAddr;
    logic [REG_WIDTH-1:0]  O_MemWData;
    logic                  I_MemAck;
    logic [REG_WIDTH-1:0]  I_MemRData;

    modport master (
        output O_MemReq, O_MemWe, O_MemAddr, O_MemWData,
        input  I_MemAck, I_MemRData
    );

    modport slave (
        input  O_MemReq, O_MemWe, O_MemAddr, O_MemWData,
        output I_MemAck, I_MemRData
    );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage pipeline: turns LDW/STW into req/ack data-memory
// transactions, passes ALU results and PC redirects through to Writeback, and
// stalls upstream while an access is outstanding (with a timeout guard).
// All state updates happen on the falling clock edge.
// Opcode encoding: ADD 00, ADDI 01, AND 02, ANDI 03, MOV 04, MOVI 05,
// LDW 10, STW 11, BR* 20..27, JMP 30, JSR 31, JSRR 32.
module memory_stage #(
    parameter int REG_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int TIMEOUT      = 16
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic [REG_WIDTH-1:0]    I_ALUOut,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]    I_DestValue,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    output logic                    O_MemStall,
    memory_stage_if.master          mem,
    output logic                    O_LOCK,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [3:0]              O_DestRegIdx,
    output logic [REG_WIDTH-1:0]    O_WBValue,
    output logic                    O_WBEn,
    output logic                    O_PCValid,
    output logic [REG_WIDTH-1:0]    O_NewPC,
    output logic                    O_MemError
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD     = OPCODE_WIDTH'(8'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI    = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND     = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI    = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV     = OPCODE_WIDTH'(8'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI    = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW     = OPCODE_WIDTH'(8'h10);
    localparam logic [OPCODE_WIDTH-1:0] OP_STW     = OPCODE_WIDTH'(8'h11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BR_BASE = OPCODE_WIDTH'(8'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_BR_MASK = OPCODE_WIDTH'(8'hF8);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP     = OPCODE_WIDTH'(8'h30);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR     = OPCODE_WIDTH'(8'h31);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR    = OPCODE_WIDTH'(8'h32);

    // Counter holds the number of ack-less WAIT edges already seen, so the
    // abort fires on the TIMEOUT-th such edge.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic is_bubble;
    logic is_load;
    logic is_store;
    logic is_wb_op;
    logic is_pc_op;

    assign is_bubble = !I_LOCK || (I_FetchStall && I_DepStall);
    assign is_load   = (I_Opcode == OP_LDW);
    assign is_store  = (I_Opcode == OP_STW);
    assign is_wb_op  = (I_Opcode == OP_ADD)  || (I_Opcode == OP_ADDI) ||
                       (I_Opcode == OP_AND)  || (I_Opcode == OP_ANDI) ||
                       (I_Opcode == OP_MOV)  || (I_Opcode == OP_MOVI) ||
                       (I_Opcode == OP_JSR)  || (I_Opcode == OP_JSRR);
    assign is_pc_op  = ((I_Opcode & OP_BR_MASK) == OP_BR_BASE) ||
                       (I_Opcode == OP_JMP) || (I_Opcode == OP_JSR) ||
                       (I_Opcode == OP_JSRR);

    // Stage FSM: issue/complete memory transactions and register Writeback outputs.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            O_MemStall     <= 1'b0;
            mem.O_MemReq   <= 1'b0;
            mem.O_MemWe    <= 1'b0;
            mem.O_MemAddr  <= '0;
            mem.O_MemWData <= '0;
            O_LOCK         <= 1'b0;
            O_Opcode       <= '0;
            O_DestRegIdx   <= '0;
            O_WBValue      <= '0;
            O_WBEn         <= 1'b0;
            O_PCValid      <= 1'b0;
            O_NewPC        <= '0;
            O_MemError     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    O_Opcode     <= I_Opcode;
                    O_DestRegIdx <= I_DestRegIdx;
                    if (!is_bubble && (is_load || is_store)) begin
                        // Launch the access; Writeback sees a bubble until it completes.
                        mem.O_MemReq  <= 1'b1;
                        O_MemStall    <= 1'b1;
                        mem.O_MemWe   <= is_store;
                        mem.O_MemAddr <= I_ALUOut[ADDR_WIDTH-1:0];
                        if (is_store) begin
                            mem.O_MemWData <= I_DestValue;
                        end
                        O_LOCK    <= 1'b0;
                        O_WBEn    <= 1'b0;
                        O_PCValid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end else begin
                        O_LOCK    <= !is_bubble;
                        O_WBValue <= I_ALUOut;
                        O_WBEn    <= !is_bubble && is_wb_op;
                        O_PCValid <= !is_bubble && is_pc_op;
                        if (!is_bubble && is_pc_op) begin
                            O_NewPC <= I_DestValue;
                        end
                    end
                end
                S_WAIT: begin
                    // An ack on the final timeout edge still completes the access.
                    if (mem.I_MemAck) begin
                        mem.O_MemReq <= 1'b0;
                        O_MemStall   <= 1'b0;
                        O_LOCK       <= 1'b1;
                        O_WBEn       <= !mem.O_MemWe;
                        if (!mem.O_MemWe) begin
                            O_WBValue <= mem.I_MemRData;
                        end
                        state <= S_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem.O_MemReq <= 1'b0;
                        O_MemStall   <= 1'b0;
                        O_LOCK       <= 1'b0;
                        O_WBEn       <= 1'b0;
                        O_MemError   <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for single-cycle ops, hand-written
// memory/timeout/reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_memory_stage;

    localparam int TO = 4;

    localparam logic [7:0] ADD  = 8'h00;
    localparam logic [7:0] ADDI = 8'h01;
    localparam logic [7:0] ANDO = 8'h02;
    localparam logic [7:0] ANDI = 8'h03;
    localparam logic [7:0] MOV  = 8'h04;
    localparam logic [7:0] MOVI = 8'h05;
    localparam logic [7:0] LDW  = 8'h10;
    localparam logic [7:0] STW  = 8'h11;
    localparam logic [7:0] BRZ  = 8'h23;
    localparam logic [7:0] JMP  = 8'h30;
    localparam logic [7:0] JSR  = 8'h31;
    localparam logic [7:0] JSRR = 8'h32;
    localparam logic [7:0] BAD  = 8'h7F;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET;
    logic        I_LOCK;
    logic [15:0] I_ALUOut;
    logic [7:0]  I_Opcode;
    logic [3:0]  I_DestRegIdx;
    logic [15:0] I_DestValue;
    logic        I_FetchStall;
    logic        I_DepStall;
    logic        O_MemStall;
    logic        O_LOCK;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestRegIdx;
    logic [15:0] O_WBValue;
    logic        O_WBEn;
    logic        O_PCValid;
    logic [15:0] O_NewPC;
    logic        O_MemError;

    memory_stage_if #(.REG_WIDTH(16), .ADDR_WIDTH(16)) mif ();

    memory_stage #(
        .REG_WIDTH(16), .OPCODE_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(TO)
    ) dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK),
        .I_ALUOut(I_ALUOut), .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx),
        .I_DestValue(I_DestValue), .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall),
        .O_MemStall(O_MemStall), .mem(mif.master), .O_LOCK(O_LOCK),
        .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx), .O_WBValue(O_WBValue),
        .O_WBEn(O_WBEn), .O_PCValid(O_PCValid), .O_NewPC(O_NewPC), .O_MemError(O_MemError)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        lock, fs, ds;
        logic [7:0]  op;
        logic [15:0] alu;
        logic [3:0]  dst;
        logic [15:0] dv;
        logic        e_lock, e_wben, e_pcv;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT updates on negedge; return at the following posedge so outputs are settled.
    task automatic tick();
        @(negedge I_CLOCK);
        @(posedge I_CLOCK);
    endtask

    task automatic drive(input logic lock, input logic [7:0] op, input logic [15:0] alu,
                         input logic [3:0] dst, input logic [15:0] dv);
        I_LOCK = lock; I_Opcode = op; I_ALUOut = alu; I_DestRegIdx = dst;
        I_DestValue = dv; I_FetchStall = 1'b0; I_DepStall = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(O_MemStall), 0);
        chk({tag, "_req"},   32'(mif.O_MemReq), 0);
        chk({tag, "_we"},    32'(mif.O_MemWe), 0);
        chk({tag, "_addr"},  32'(mif.O_MemAddr), 0);
        chk({tag, "_wdata"}, 32'(mif.O_MemWData), 0);
        chk({tag, "_lock"},  32'(O_LOCK), 0);
        chk({tag, "_op"},    32'(O_Opcode), 0);
        chk({tag, "_dst"},   32'(O_DestRegIdx), 0);
        chk({tag, "_wbv"},   32'(O_WBValue), 0);
        chk({tag, "_wben"},  32'(O_WBEn), 0);
        chk({tag, "_pcv"},   32'(O_PCValid), 0);
        chk({tag, "_npc"},   32'(O_NewPC), 0);
        chk({tag, "_err"},   32'(O_MemError), 0);
    endtask

    // Reference model: which opcodes write a register / redirect the PC.
    function automatic logic m_wb(input logic [7:0] op);
        return op inside {ADD, ADDI, ANDO, ANDI, MOV, MOVI, JSR, JSRR};
    endfunction

    function automatic logic m_pc(input logic [7:0] op);
        return (op inside {[8'h20:8'h27]}) || (op inside {JMP, JSR, JSRR});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        exp_err;
        logic        bub, issue, ld, ack;
        logic [15:0] rd, a_alu, a_dv;
        logic [7:0]  op;
        int          k, idx;

        I_RESET = 1'b1;
        drive(0, ADD, 0, 0, 0);
        mif.I_MemAck = 1'b0; mif.I_MemRData = '0;
        tick(); tick();
        chk_all_zero("reset");
        I_RESET = 1'b0;

        // ---- table-driven single-cycle ops ----
        vt[0]  = '{1,0,0, ADDI, 16'h0012, 4'd3,  16'h0000, 1,1,0};
        vt[1]  = '{1,0,0, ADD,  16'hA5A5, 4'd7,  16'h0000, 1,1,0};
        vt[2]  = '{1,0,0, ANDO, 16'h0F0F, 4'd1,  16'h5555, 1,1,0};
        vt[3]  = '{1,0,0, MOVI, 16'hFFFF, 4'd15, 16'h0000, 1,1,0};
        vt[4]  = '{1,0,0, BRZ,  16'h1111, 4'd2,  16'h2000, 1,0,1};
        vt[5]  = '{1,0,0, JMP,  16'h0000, 4'd0,  16'h0300, 1,0,1};
        vt[6]  = '{1,0,0, JSR,  16'h0042, 4'd7,  16'h0400, 1,1,1};
        vt[7]  = '{1,0,0, JSRR, 16'h0044, 4'd7,  16'h0500, 1,1,1};
        vt[8]  = '{0,0,0, ADD,  16'h1234, 4'd4,  16'h0000, 0,0,0};
        vt[9]  = '{1,1,1, ADD,  16'h1234, 4'd4,  16'h0000, 0,0,0};
        vt[10] = '{1,1,0, JMP,  16'h0000, 4'd0,  16'h0700, 1,0,1};
        vt[11] = '{1,0,0, BAD,  16'h3333, 4'd5,  16'h0800, 1,0,0};
        vt[12] = '{1,0,1, JSR,  16'h0042, 4'd7,  16'h0900, 1,1,1};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].lock, vt[i].op, vt[i].alu, vt[i].dst, vt[i].dv);
            I_FetchStall = vt[i].fs; I_DepStall = vt[i].ds;
            tick();
            chk($sformatf("vec%0d_lock", i), 32'(O_LOCK), 32'(vt[i].e_lock));
            chk($sformatf("vec%0d_wben", i), 32'(O_WBEn), 32'(vt[i].e_wben));
            chk($sformatf("vec%0d_pcv", i),  32'(O_PCValid), 32'(vt[i].e_pcv));
            chk($sformatf("vec%0d_req", i),  32'(mif.O_MemReq), 0);
            if (vt[i].e_lock) begin
                chk($sformatf("vec%0d_wbv", i), 32'(O_WBValue), 32'(vt[i].alu));
                chk($sformatf("vec%0d_dst", i), 32'(O_DestRegIdx), 32'(vt[i].dst));
            end
            if (vt[i].e_pcv)
                chk($sformatf("vec%0d_npc", i), 32'(O_NewPC), 32'(vt[i].dv));
        end

        // ---- LDW, ack after 3 edges ----
        drive(1, LDW, 16'h0040, 4'd6, 16'h0000);
        tick();
        chk("ld_req0", 32'(mif.O_MemReq), 1);
        chk("ld_stall0", 32'(O_MemStall), 1);
        chk("ld_we0", 32'(mif.O_MemWe), 0);
        chk("ld_addr0", 32'(mif.O_MemAddr), 32'h0040);
        chk("ld_lock0", 32'(O_LOCK), 0);
        drive(1, ADD, 16'h9999, 4'd1, 16'h0000);
        tick();
        chk("ld_req1", 32'(mif.O_MemReq), 1);
        tick();
        chk("ld_req2", 32'(mif.O_MemReq), 1);
        chk("ld_addr2", 32'(mif.O_MemAddr), 32'h0040);
        mif.I_MemAck = 1'b1; mif.I_MemRData = 16'hBEEF;
        tick();
        mif.I_MemAck = 1'b0;
        chk("ld_req3", 32'(mif.O_MemReq), 0);
        chk("ld_stall3", 32'(O_MemStall), 0);
        chk("ld_lock3", 32'(O_LOCK), 1);
        chk("ld_wbv", 32'(O_WBValue), 32'hBEEF);
        chk("ld_wben", 32'(O_WBEn), 1);
        chk("ld_dst", 32'(O_DestRegIdx), 6);

        // ---- STW, ack after 1 edge ----
        drive(1, STW, 16'h0008, 4'd2, 16'h1234);
        tick();
        chk("st_we", 32'(mif.O_MemWe), 1);
        chk("st_wdata", 32'(mif.O_MemWData), 32'h1234);
        chk("st_addr", 32'(mif.O_MemAddr), 32'h0008);
        mif.I_MemAck = 1'b1; mif.I_MemRData = 16'hDEAD;
        tick();
        mif.I_MemAck = 1'b0;
        chk("st_lock", 32'(O_LOCK), 1);
        chk("st_wben", 32'(O_WBEn), 0);
        chk("st_req", 32'(mif.O_MemReq), 0);

        // ---- ack exactly on the timeout edge ----
        drive(1, LDW, 16'h0050, 4'd9, 16'h0000);
        tick();
        for (int j = 1; j < TO; j++) tick();
        chk("edge_req", 32'(mif.O_MemReq), 1);
        mif.I_MemAck = 1'b1; mif.I_MemRData = 16'hCAFE;
        tick();
        mif.I_MemAck = 1'b0;
        chk("edge_lock", 32'(O_LOCK), 1);
        chk("edge_wbv", 32'(O_WBValue), 32'hCAFE);
        chk("edge_err", 32'(O_MemError), 0);

        // ---- stray ack while idle ----
        drive(0, ADD, 16'h0000, 4'd0, 16'h0000);
        mif.I_MemAck = 1'b1; mif.I_MemRData = 16'h7777;
        tick();
        chk("stray_req", 32'(mif.O_MemReq), 0);
        chk("stray_lock", 32'(O_LOCK), 0);
        chk("stray_wben", 32'(O_WBEn), 0);
        drive(1, ADD, 16'h0abc, 4'd3, 16'h0000);
        tick();
        mif.I_MemAck = 1'b0;
        chk("stray_wbv", 32'(O_WBValue), 32'h0abc);
        chk("stray_stall", 32'(O_MemStall), 0);
        chk("stray_err", 32'(O_MemError), 0);

        // ---- timeout ----
        drive(1, LDW, 16'h0060, 4'd4, 16'h0000);
        tick();
        for (int j = 1; j < TO; j++) begin
            tick();
            chk($sformatf("to_req%0d", j), 32'(mif.O_MemReq), 1);
        end
        tick();
        chk("to_req", 32'(mif.O_MemReq), 0);
        chk("to_stall", 32'(O_MemStall), 0);
        chk("to_lock", 32'(O_LOCK), 0);
        chk("to_err", 32'(O_MemError), 1);
        drive(1, ADD, 16'h0123, 4'd5, 16'h0000);
        tick();
        chk("to_add_lock", 32'(O_LOCK), 1);
        chk("to_add_wbv", 32'(O_WBValue), 32'h0123);
        chk("to_err_sticky", 32'(O_MemError), 1);

        // ---- reset mid-WAIT ----
        drive(1, STW, 16'h0070, 4'd8, 16'h4444);
        tick(); tick();
        I_RESET = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        tick();
        I_RESET = 1'b0;
        drive(1, JMP, 16'h0000, 4'd0, 16'h0100);
        tick();
        chk("jmp_pcv", 32'(O_PCValid), 1);
        chk("jmp_npc", 32'(O_NewPC), 32'h0100);
        chk("jmp_wben", 32'(O_WBEn), 0);

        // ---- randomized traffic vs transaction model ----
        exp_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            idx = $urandom_range(0, 12);
            case (idx)
                0: op = ADD;  1: op = ADDI; 2: op = ANDO; 3: op = ANDI;
                4: op = MOV;  5: op = MOVI; 6: op = LDW;  7: op = STW;
                8: op = 8'h20 + 8'($urandom_range(0, 7));
                9: op = JMP;  10: op = JSR; 11: op = JSRR;
                default: op = BAD;
            endcase
            a_alu = 16'($urandom); a_dv = 16'($urandom);
            drive($urandom_range(0, 9) != 0, op, a_alu, 4'($urandom), a_dv);
            I_FetchStall = ($urandom_range(0, 3) == 0);
            I_DepStall   = ($urandom_range(0, 3) == 0);
            mif.I_MemAck = ($urandom_range(0, 3) == 0);
            mif.I_MemRData = 16'($urandom);
            bub   = !I_LOCK || (I_FetchStall && I_DepStall);
            issue = !bub && (op == LDW || op == STW);
            ld    = (op == LDW);
            tick();
            mif.I_MemAck = 1'b0;
            if (issue) begin
                chk("r_req", 32'(mif.O_MemReq), 1);
                chk("r_addr", 32'(mif.O_MemAddr), 32'(a_alu));
                chk("r_we", 32'(mif.O_MemWe), 32'(!ld));
                if (!ld) chk("r_wdata", 32'(mif.O_MemWData), 32'(a_dv));
                k = $urandom_range(1, TO + 1);
                for (int j = 1; j <= TO; j++) begin
                    ack = (j == k);
                    rd  = 16'($urandom);
                    drive($urandom_range(0, 1) == 1, 8'($urandom), 16'($urandom), 4'($urandom), 16'($urandom));
                    mif.I_MemAck = ack; mif.I_MemRData = rd;
                    tick();
                    mif.I_MemAck = 1'b0;
                    if (ack) begin
                        chk("r_ack_req", 32'(mif.O_MemReq), 0);
                        chk("r_ack_lock", 32'(O_LOCK), 1);
                        chk("r_ack_wben", 32'(O_WBEn), 32'(ld));
                        if (ld) chk("r_ack_wbv", 32'(O_WBValue), 32'(rd));
                        break;
                    end else if (j == TO) begin
                        exp_err = 1'b1;
                        chk("r_to_req", 32'(mif.O_MemReq), 0);
                        chk("r_to_lock", 32'(O_LOCK), 0);
                    end else begin
                        chk("r_wait_stall", 32'(O_MemStall), 1);
                        chk("r_wait_addr", 32'(mif.O_MemAddr), 32'(a_alu));
                        chk("r_wait_lock", 32'(O_LOCK), 0);
                    end
                end
            end else begin
                chk("r_lock", 32'(O_LOCK), 32'(!bub));
                chk("r_wben", 32'(O_WBEn), 32'(!bub && m_wb(op)));
                chk("r_pcv", 32'(O_PCValid), 32'(!bub && m_pc(op)));
                chk("r_stall", 32'(O_MemStall), 0);
                if (!bub) chk("r_wbv", 32'(O_WBValue), 32'(a_alu));
                if (!bub && m_pc(op)) chk("r_npc", 32'(O_NewPC), 32'(a_dv));
            end
            chk("r_err", 32'(O_MemError), 32'(exp_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
